// File: rtl/mem_perf_monitor.sv
// mem_perf_monitor: passive monitor on the cluster-to-memory request/response
// bus. Counts fired reads and writes, accumulates outstanding-read latency and
// (optionally) back-to-back same-address requests. Never touches the bus.
//
// Build option: define MEM_PERF_SAME_ACCESS_EN to enable same-address
// tracking; when undefined, same_access is tied to zero.
//
// Pipeline: fire events are registered in stage 1 and accumulated into the
// counters in stage 2, so an event firing in cycle N is visible in cycle N+2.
// pending_reads and perf_err are updated directly (not staged).
module mem_perf_monitor #(
    parameter int ADDR_WIDTH  = 26,
    parameter int CTR_WIDTH   = 44,
    parameter int MAX_PENDING = 64,
    localparam int PEND_W     = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    input  logic                  mem_req_rw,
    input  logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic                  mem_rsp_ready,
    output logic [CTR_WIDTH-1:0]  mem_reads,
    output logic [CTR_WIDTH-1:0]  mem_writes,
    output logic [CTR_WIDTH-1:0]  mem_latency,
    output logic [CTR_WIDTH-1:0]  same_access,
    output logic [PEND_W-1:0]     pending_reads,
    output logic                  perf_err
);

    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic req_fire;
    logic rsp_fire;
    logic rd_fire;
    logic wr_fire;
    logic same_hit;

    assign req_fire = mem_req_valid & mem_req_ready;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;
    assign rd_fire  = req_fire & ~mem_req_rw;
    assign wr_fire  = req_fire & mem_req_rw;

    // ------------------------------------------------------------------
    // Outstanding-read tracking
    // ------------------------------------------------------------------
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              perf_err_q, perf_err_d;
    logic              err_set;

    // Saturating pending count; overflow/underflow raise the sticky error.
    always_comb begin
        pending_d = pending_q;
        err_set   = 1'b0;
        if (rd_fire && !rsp_fire) begin
            if (pending_q == PEND_MAX) begin
                err_set = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (rsp_fire && !rd_fire) begin
            if (pending_q == '0) begin
                err_set = 1'b1;
            end else begin
                pending_d = pending_q - PEND_W'(1);
            end
        end
        // clear leaves pending alone since traffic is still in flight
        perf_err_d = clear ? 1'b0 : (perf_err_q | err_set);
    end

    // Pending count and sticky error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= '0;
            perf_err_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            perf_err_q <= perf_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Same-address detection
    // ------------------------------------------------------------------
`ifdef MEM_PERF_SAME_ACCESS_EN
    logic [ADDR_WIDTH-1:0] prev_addr_q, prev_addr_d;
    logic                  prev_valid_q, prev_valid_d;

    // Remember the last fired address; clear forces the next request to miss.
    always_comb begin
        same_hit     = req_fire & prev_valid_q & (mem_req_addr == prev_addr_q);
        prev_addr_d  = req_fire ? mem_req_addr : prev_addr_q;
        prev_valid_d = clear ? 1'b0 : (prev_valid_q | req_fire);
    end

    // Previous-request address registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_addr_q  <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            prev_addr_q  <= prev_addr_d;
            prev_valid_q <= prev_valid_d;
        end
    end
`else
    logic unused_addr;
    assign unused_addr = ^mem_req_addr;
    assign same_hit    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Stage 1: registered events and latency snapshot
    // ------------------------------------------------------------------
    logic              s1_rd_q, s1_rd_d;
    logic              s1_wr_q, s1_wr_d;
    logic              s1_same_q, s1_same_d;
    logic [PEND_W-1:0] s1_snap_q, s1_snap_d;

    // Capture this cycle's events; snapshot is pending before its update.
    always_comb begin
        s1_rd_d   = clear ? 1'b0 : rd_fire;
        s1_wr_d   = clear ? 1'b0 : wr_fire;
        s1_same_d = clear ? 1'b0 : same_hit;
        s1_snap_d = clear ? '0   : pending_q;
    end

    // Stage 1 registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_rd_q   <= 1'b0;
            s1_wr_q   <= 1'b0;
            s1_same_q <= 1'b0;
            s1_snap_q <= '0;
        end else begin
            s1_rd_q   <= s1_rd_d;
            s1_wr_q   <= s1_wr_d;
            s1_same_q <= s1_same_d;
            s1_snap_q <= s1_snap_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: wrapping counters
    // ------------------------------------------------------------------
    logic [CTR_WIDTH-1:0] reads_q, reads_d;
    logic [CTR_WIDTH-1:0] writes_q, writes_d;
    logic [CTR_WIDTH-1:0] latency_q, latency_d;
    logic [CTR_WIDTH-1:0] same_q, same_d;

    // Accumulate stage-1 events; clear drops whatever is still in stage 1.
    always_comb begin
        if (clear) begin
            reads_d   = '0;
            writes_d  = '0;
            latency_d = '0;
            same_d    = '0;
        end else begin
            reads_d   = reads_q   + CTR_WIDTH'(s1_rd_q);
            writes_d  = writes_q  + CTR_WIDTH'(s1_wr_q);
            latency_d = latency_q + CTR_WIDTH'(s1_snap_q);
            same_d    = same_q    + CTR_WIDTH'(s1_same_q);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reads_q   <= '0;
            writes_q  <= '0;
            latency_q <= '0;
            same_q    <= '0;
        end else begin
            reads_q   <= reads_d;
            writes_q  <= writes_d;
            latency_q <= latency_d;
            same_q    <= same_d;
        end
    end

    assign mem_reads     = reads_q;
    assign mem_writes    = writes_q;
    assign mem_latency   = latency_q;
`ifdef MEM_PERF_SAME_ACCESS_EN
    assign same_access   = same_q;
`else
    assign same_access   = '0;
`endif
    assign pending_reads = pending_q;
    assign perf_err      = perf_err_q;

endmodule

// File: tb/tb_mem_perf_monitor.sv
// Testbench for mem_perf_monitor. Directed scenarios followed by randomized
// traffic; expected outputs come from a windowed-sum reference model and are
// queued per cycle, then popped and compared by an independent monitor.
module tb_mem_perf_monitor;

    localparam int AW  = 4;
    localparam int CW  = 44;
    localparam int MP  = 4;
    localparam int PW  = $clog2(MP + 1);
    localparam int NCY = 4096;
`ifdef MEM_PERF_SAME_ACCESS_EN
    localparam bit SAME_EN = 1'b1;
`else
    localparam bit SAME_EN = 1'b0;
`endif

    logic          clk;
    logic          reset_n;
    logic          clear;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [CW-1:0] mem_reads, mem_writes, mem_latency, same_access;
    logic [PW-1:0] pending_reads;
    logic          perf_err;

    mem_perf_monitor #(
        .ADDR_WIDTH (AW),
        .CTR_WIDTH  (CW),
        .MAX_PENDING(MP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_rw   (mem_req_rw),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_ready(mem_rsp_ready),
        .mem_reads    (mem_reads),
        .mem_writes   (mem_writes),
        .mem_latency  (mem_latency),
        .same_access  (same_access),
        .pending_reads(pending_reads),
        .perf_err     (perf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint unsigned rd;
        longint unsigned wr;
        longint unsigned lat;
        longint unsigned same;
        longint unsigned pend;
        bit              err;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // cum_x[k] = total of event x over cycles 0..k-1 of the current epoch.
    // Counters seen in cycle c+1 = events of cycles (last_clear, c-1].
    longint unsigned cum_rd[NCY], cum_wr[NCY], cum_lat[NCY], cum_same[NCY];
    int              cyc, last_clear, last_err, last_fire, pend;
    logic [AW-1:0]   last_fire_addr;

    task automatic model_reset();
        cyc        = 0;
        last_clear = -1;
        last_err   = -1;
        last_fire  = -1;
        pend       = 0;
        cum_rd[0] = 0; cum_wr[0] = 0; cum_lat[0] = 0; cum_same[0] = 0;
    endtask

    // Apply one cycle of inputs, predict the outputs after the next edge.
    task automatic drive(input bit rst, input bit v, input bit r, input bit rw,
                         input logic [AW-1:0] a, input bit rv, input bit rr, input bit clr);
        exp_t e;
        int   c;
        bit   fire, rdf, wrf, rspf, hit;
        reset_n       = !rst;
        clear         = clr;
        mem_req_valid = v;
        mem_req_ready = r;
        mem_req_rw    = rw;
        mem_req_addr  = a;
        mem_rsp_valid = rv;
        mem_rsp_ready = rr;
        e = '{0, 0, 0, 0, 0, 1'b0};
        if (rst) begin
            model_reset();
            #1;
            check("async_rst_pending", 64'(pending_reads), 0);
            check("async_rst_reads", 64'(mem_reads), 0);
        end else begin
            c    = cyc;
            fire = v & r;
            rdf  = fire & !rw;
            wrf  = fire & rw;
            rspf = rv & rr;
            hit  = SAME_EN && fire && (last_fire > last_clear) && (a == last_fire_addr);
            cum_lat[c+1]  = cum_lat[c] + longint'(pend);
            cum_rd[c+1]   = cum_rd[c] + longint'(rdf);
            cum_wr[c+1]   = cum_wr[c] + longint'(wrf);
            cum_same[c+1] = cum_same[c] + longint'(hit);
            if (rdf && !rspf) begin
                if (pend == MP) last_err = c; else pend++;
            end else if (rspf && !rdf) begin
                if (pend == 0) last_err = c; else pend--;
            end
            if (fire) begin
                last_fire      = c;
                last_fire_addr = a;
            end
            if (clr) last_clear = c;
            if (last_clear + 1 < c) begin
                e.rd   = cum_rd[c]   - cum_rd[last_clear+1];
                e.wr   = cum_wr[c]   - cum_wr[last_clear+1];
                e.lat  = cum_lat[c]  - cum_lat[last_clear+1];
                e.same = cum_same[c] - cum_same[last_clear+1];
            end
            e.pend = longint'(pend);
            e.err  = (last_err > last_clear);
            cyc++;
        end
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("mem_reads", 64'(mem_reads), e.rd);
                check("mem_writes", 64'(mem_writes), e.wr);
                check("mem_latency", 64'(mem_latency), e.lat);
                check("same_access", 64'(same_access), e.same);
                check("pending_reads", 64'(pending_reads), e.pend);
                check("perf_err", 64'(perf_err), 64'(e.err));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; clear = 1'b0;
        mem_req_valid = 1'b0; mem_req_ready = 1'b0; mem_req_rw = 1'b0;
        mem_req_addr = '0; mem_rsp_valid = 1'b0; mem_rsp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) drive(1, 0, 0, 0, '0, 0, 0, 0);

        // basic read: fire in cycle 0, response in cycle 4
        drive(0, 1, 1, 0, 4'h1, 0, 0, 0);
        check("basic_pending_c1", 64'(pending_reads), 1);
        repeat (3) idle();
        check("basic_pending_c4", 64'(pending_reads), 1);
        drive(0, 0, 0, 0, '0, 1, 1, 0);
        check("basic_pending_c5", 64'(pending_reads), 0);
        idle();
        check("basic_reads", 64'(mem_reads), 1);
        check("basic_latency", 64'(mem_latency), 4);

        // backpressure: write held without ready, then accepted once
        repeat (5) drive(0, 1, 0, 1, 4'h5, 0, 0, 0);
        drive(0, 1, 1, 1, 4'h5, 0, 0, 0);
        idle(); idle();
        check("bp_writes", 64'(mem_writes), 1);
        check("bp_reads", 64'(mem_reads), 1);

        // same address pattern A, A, B, A
        drive(0, 1, 1, 1, 4'h9, 0, 0, 0);
        drive(0, 1, 1, 1, 4'h9, 0, 0, 0);
        drive(0, 1, 1, 1, 4'h3, 0, 0, 0);
        drive(0, 1, 1, 1, 4'h9, 0, 0, 0);
        idle(); idle();
        check("same_aaba", 64'(same_access), 64'(SAME_EN));
        check("same_writes", 64'(mem_writes), 5);

        // simultaneous read fire and response with pending = 3
        drive(0, 1, 1, 0, 4'h2, 0, 0, 0);
        drive(0, 1, 1, 0, 4'h6, 0, 0, 0);
        drive(0, 1, 1, 0, 4'h7, 0, 0, 0);
        drive(0, 1, 1, 0, 4'h8, 1, 1, 0);
        check("simul_pending", 64'(pending_reads), 3);
        idle(); idle();
        check("simul_reads", 64'(mem_reads), 5);

        // overflow: pending saturates at MAX_PENDING
        drive(0, 1, 1, 0, 4'ha, 0, 0, 0);
        drive(0, 1, 1, 0, 4'hb, 0, 0, 0);
        check("ovf_pending", 64'(pending_reads), MP);
        check("ovf_err", 64'(perf_err), 1);

        // reset mid-operation, then a stray response underflows
        repeat (2) drive(1, 0, 0, 0, '0, 0, 0, 0);
        drive(0, 0, 0, 0, '0, 1, 1, 0);
        check("udf_pending", 64'(pending_reads), 0);
        check("udf_err", 64'(perf_err), 1);

        // clear: 10 reads, clear cycle with one more read
        drive(0, 1, 1, 0, 4'h1, 0, 0, 0);
        repeat (9) drive(0, 1, 1, 0, 4'h1, 1, 1, 0);
        drive(0, 1, 1, 0, 4'h4, 0, 0, 1);
        idle();
        check("clr_reads", 64'(mem_reads), 0);
        check("clr_latency", 64'(mem_latency), 0);
        check("clr_err", 64'(perf_err), 0);
        check("clr_pending", 64'(pending_reads), 2);
        idle();
        check("clr_read_dropped", 64'(mem_reads), 0);
        check("clr_latency_after", 64'(mem_latency), 2);

        // randomized traffic with occasional clear and one mid-run reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                repeat (2) drive(1, 0, 0, 0, '0, 0, 0, 0);
            end else begin
                drive(0,
                      ($urandom_range(0, 9) < 7),
                      ($urandom_range(0, 9) < 7),
                      $urandom_range(0, 1) == 1,
                      AW'($urandom_range(0, 5)),
                      ($urandom_range(0, 9) < 5),
                      ($urandom_range(0, 9) < 7),
                      ($urandom_range(0, 79) == 0));
            end
        end
        repeat (3) idle();
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
